// File: rtl/frog_pkg.sv
// Shared definitions for the Frogger game-state sequencer: geometry, game
// constants, state/move encodings and score arithmetic.
// No logic of its own; imported by frog_btn_edge and frog_ctrl.
package frog_pkg;

  localparam logic [9:0] X_START = 10'd312;
  localparam logic [9:0] Y_START = 10'd448;
  localparam logic [9:0] STEP_X  = 10'd16;
  localparam logic [9:0] STEP_Y  = 10'd32;
  localparam logic [9:0] X_MAX   = 10'd624;
  localparam logic [9:0] Y_HOME  = 10'd64;

  localparam logic [2:0] LIVES        = 3'd3;
  localparam logic [2:0] HOMES        = 3'd5;
  localparam logic [5:0] DEATH_FRAMES = 6'd30;

  localparam logic [11:0] SCORE_STEP = 12'd10;
  localparam logic [11:0] SCORE_HOME = 12'd50;
  localparam logic [11:0] SCORE_MAX  = 12'd4095;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLAY      = 3'd1,
    ST_DYING     = 3'd2,
    ST_GAME_OVER = 3'd3,
    ST_WIN       = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    MV_UP    = 2'd0,
    MV_DOWN  = 2'd1,
    MV_LEFT  = 2'd2,
    MV_RIGHT = 2'd3
  } move_e;

  // Saturating score addition.
  function automatic logic [11:0] sat_add(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[12] ? SCORE_MAX : s[11:0];
  endfunction

endpackage

// File: rtl/frog_btn_edge.sv
// Button front end: registers the four direction buttons and start, detects
// rising edges, and holds one prioritized pending move (up > down > left > right).
// Latency: pending move valid one clock after the edge; start_edge_o is combinational.
// Backpressure: while a move is pending further edges are dropped; clr_i empties it.
// Ports: clk_i, rst_ni; up_i/down_i/left_i/right_i/start_i button levels;
//        clr_i consume/flush; pend_vld_o, pend_mv_o pending move; start_edge_o.
module frog_btn_edge
  import frog_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  up_i,
  input  logic  down_i,
  input  logic  left_i,
  input  logic  right_i,
  input  logic  start_i,
  input  logic  clr_i,
  output logic  pend_vld_o,
  output move_e pend_mv_o,
  output logic  start_edge_o
);

  logic [4:0] btn_q;      // {start, up, down, left, right}
  logic [3:0] dir_edge;   // {up, down, left, right}
  logic       pend_vld_q;
  move_e      pend_mv_q;
  move_e      mv_sel;

  assign dir_edge     = {up_i, down_i, left_i, right_i} & ~btn_q[3:0];
  assign start_edge_o = start_i & ~btn_q[4];

  always_comb begin
    mv_sel = MV_RIGHT;
    if (dir_edge[3])      mv_sel = MV_UP;
    else if (dir_edge[2]) mv_sel = MV_DOWN;
    else if (dir_edge[1]) mv_sel = MV_LEFT;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      btn_q      <= '0;
      pend_vld_q <= 1'b0;
      pend_mv_q  <= MV_UP;
    end else begin
      btn_q <= {start_i, up_i, down_i, left_i, right_i};
      // A clear in the same cycle as an edge wins, so nothing slips in
      // while the consumer is not accepting moves.
      if (clr_i) begin
        pend_vld_q <= 1'b0;
      end else if (!pend_vld_q && (|dir_edge)) begin
        pend_vld_q <= 1'b1;
        pend_mv_q  <= mv_sel;
      end
    end
  end

  assign pend_vld_o = pend_vld_q;
  assign pend_mv_o  = pend_mv_q;

endmodule

// File: rtl/frog_ctrl.sv
// Frogger game-state sequencer: applies pending hops, hazards, homes and lives per frame.
// Latency: all outputs registered, updating one clock after the frame_tick cycle.
// Backpressure: one move is buffered per frame; extra button edges are dropped.
// Ports: clk_100MHz, reset (async active-low); up/down/left/right/start buttons;
//        frame_tick, hazard; frog_x/frog_y, lives, homes, state, frog_visible, score.
// Optional macro FROG_SCORE_EN enables the score counter (score is 0 otherwise).
module frog_ctrl
  import frog_pkg::*;
(
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic        frame_tick,
  input  logic        hazard,
  input  logic        start,
  output logic [9:0]  frog_x,
  output logic [9:0]  frog_y,
  output logic [2:0]  lives,
  output logic [2:0]  homes,
  output logic [2:0]  state,
  output logic        frog_visible,
  output logic [11:0] score
);

  logic        start_edge, pend_vld, pend_clr, start_req, reach_home;
  logic        start_pend_q, frog_visible_q;
  move_e       pend_mv;
  state_e      state_q;
  logic [9:0]  x_q, y_q, nx, ny;
  logic [10:0] x_sub, x_add, y_sub, y_add;
  logic [2:0]  lives_q, homes_q, homes_inc;
  logic [5:0]  cnt_q, cnt_dec;

  // Moves are only accepted in PLAY, and every PLAY frame consumes the slot.
  assign pend_clr = (state_q != ST_PLAY) || frame_tick;

  frog_btn_edge u_btn (
    .clk_i       (clk_100MHz),
    .rst_ni      (reset),
    .up_i        (up),
    .down_i      (down),
    .left_i      (left),
    .right_i     (right),
    .start_i     (start),
    .clr_i       (pend_clr),
    .pend_vld_o  (pend_vld),
    .pend_mv_o   (pend_mv),
    .start_edge_o(start_edge)
  );

  assign start_req = start_pend_q || start_edge;
  assign homes_inc = homes_q + 3'd1;
  assign cnt_dec   = cnt_q - 6'd1;

  // 11-bit intermediates: bit 10 of a difference flags underflow.
  assign x_sub = {1'b0, x_q} - {1'b0, STEP_X};
  assign x_add = {1'b0, x_q} + {1'b0, STEP_X};
  assign y_sub = {1'b0, y_q} - {1'b0, STEP_Y};
  assign y_add = {1'b0, y_q} + {1'b0, STEP_Y};

  always_comb begin
    nx = x_q;
    ny = y_q;
    case (pend_mv)
      MV_UP:    ny = y_sub[10] ? 10'd0 : y_sub[9:0];
      MV_DOWN:  ny = (y_add > {1'b0, Y_START}) ? Y_START : y_add[9:0];
      MV_LEFT:  nx = x_sub[10] ? 10'd0 : x_sub[9:0];
      MV_RIGHT: nx = (x_add > {1'b0, X_MAX}) ? X_MAX : x_add[9:0];
      default:  ;
    endcase
  end

  assign reach_home = (ny <= Y_HOME);

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      x_q            <= X_START;
      y_q            <= Y_START;
      lives_q        <= LIVES;
      homes_q        <= 3'd0;
      frog_visible_q <= 1'b1;
      cnt_q          <= 6'd0;
      start_pend_q   <= 1'b0;
    end else begin
      // Remember a start press until the next frame; ignored mid-game.
      if (start_edge && (state_q == ST_IDLE || state_q == ST_GAME_OVER || state_q == ST_WIN))
        start_pend_q <= 1'b1;
      if (frame_tick) begin
        case (state_q)
          ST_IDLE: begin
            if (start_req) begin
              state_q        <= ST_PLAY;
              lives_q        <= LIVES;
              homes_q        <= 3'd0;
              x_q            <= X_START;
              y_q            <= Y_START;
              frog_visible_q <= 1'b1;
              start_pend_q   <= 1'b0;
            end
          end
          ST_PLAY: begin
            if (hazard) begin
              lives_q        <= lives_q - 3'd1;
              cnt_q          <= DEATH_FRAMES;
              frog_visible_q <= DEATH_FRAMES[2];
              state_q        <= ST_DYING;
            end else if (pend_vld) begin
              if (reach_home) begin
                homes_q <= homes_inc;
                x_q     <= X_START;
                y_q     <= Y_START;
                if (homes_inc == HOMES) state_q <= ST_WIN;
              end else begin
                x_q <= nx;
                y_q <= ny;
              end
            end
          end
          ST_DYING: begin
            // Leave on the frame where the counter reaches zero.
            if (cnt_q <= 6'd1) begin
              cnt_q          <= 6'd0;
              frog_visible_q <= 1'b1;
              if (lives_q == 3'd0) begin
                state_q <= ST_GAME_OVER;
              end else begin
                state_q <= ST_PLAY;
                x_q     <= X_START;
                y_q     <= Y_START;
              end
            end else begin
              cnt_q          <= cnt_dec;
              frog_visible_q <= cnt_dec[2];
            end
          end
          ST_GAME_OVER, ST_WIN: begin
            if (start_req) begin
              state_q      <= ST_IDLE;
              start_pend_q <= 1'b0;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef FROG_SCORE_EN
  logic        enter_play, respawn, mv_apply;
  logic [11:0] score_q, score_d;
  logic [9:0]  min_y_q, min_y_d;

  assign enter_play = frame_tick && (state_q == ST_IDLE) && start_req;
  assign respawn    = frame_tick && (state_q == ST_DYING) && (cnt_q <= 6'd1) && (lives_q != 3'd0);
  assign mv_apply   = frame_tick && (state_q == ST_PLAY) && !hazard && pend_vld;

  // min_y tracks the best row of the current life; a home does not reset it.
  always_comb begin
    score_d = score_q;
    min_y_d = min_y_q;
    if (enter_play) begin
      score_d = 12'd0;
      min_y_d = Y_START;
    end else if (respawn) begin
      min_y_d = Y_START;
    end else if (mv_apply) begin
      if ((pend_mv == MV_UP) && (ny < min_y_q)) begin
        score_d = sat_add(score_d, SCORE_STEP);
        min_y_d = ny;
      end
      if (reach_home) score_d = sat_add(score_d, SCORE_HOME);
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      score_q <= 12'd0;
      min_y_q <= Y_START;
    end else begin
      score_q <= score_d;
      min_y_q <= min_y_d;
    end
  end

  assign score = score_q;
`else
  assign score = 12'd0;
`endif

  assign frog_x       = x_q;
  assign frog_y       = y_q;
  assign lives        = lives_q;
  assign homes        = homes_q;
  assign state        = state_q;
  assign frog_visible = frog_visible_q;

endmodule

// File: tb/tb_frog_ctrl.sv
// Scoreboard bench for frog_ctrl: each frame tick pushes its expected outputs,
// a monitor pops and compares one clock after the tick.
module tb_frog_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic        frame_tick = 1'b0, hazard = 1'b0, start = 1'b0;
  logic [9:0]  frog_x, frog_y;
  logic [2:0]  lives, homes, state;
  logic        frog_visible;
  logic [11:0] score;

  always #5 clk = ~clk;

  frog_ctrl dut (
    .clk_100MHz  (clk),
    .reset       (reset),
    .up          (up),
    .down        (down),
    .left        (left),
    .right       (right),
    .frame_tick  (frame_tick),
    .hazard      (hazard),
    .start       (start),
    .frog_x      (frog_x),
    .frog_y      (frog_y),
    .lives       (lives),
    .homes       (homes),
    .state       (state),
    .frog_visible(frog_visible),
    .score       (score)
  );

  // mask bits: 0 x, 1 y, 2 lives, 3 homes, 4 state, 5 visible, 6 score
  localparam logic [6:0] M_NONE = 7'h00, M_POS = 7'h03, M_FULL = 7'h1F,
                         M_SV = 7'h30, M_ALL = 7'h3F, M_ST = 7'h10;
  localparam logic [3:0] B_UP = 4'b1000, B_DN = 4'b0100, B_LT = 4'b0010, B_RT = 4'b0001;

`ifdef FROG_SCORE_EN
  localparam int WIN_SCORE = 370;
`else
  localparam int WIN_SCORE = 0;
`endif

  typedef struct {
    int         tag;
    logic [6:0] m;
    int         x, y, lv, hm, st, vis, sc;
  } exp_t;

  exp_t q[$];
  int   errs = 0;
  int   checks = 0;
  int   ntick = 0;

  task automatic check(input string nm, input int tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s (tick %0d): got %0d, expected %0d", nm, tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    {up, down, left, right} = d;
    cyc(1);
    {up, down, left, right} = 4'b0000;
    cyc(1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
  endtask

  task automatic tk(input logic h, input logic [6:0] m, input int x, input int y,
                    input int lv, input int hm, input int st, input int vis, input int sc);
    exp_t e;
    e.tag = ntick; e.m = m; e.x = x; e.y = y; e.lv = lv; e.hm = hm;
    e.st = st; e.vis = vis; e.sc = sc;
    ntick++;
    q.push_back(e);
    frame_tick = 1'b1;
    hazard     = h;
    cyc(1);
    frame_tick = 1'b0;
    hazard     = 1'b0;
    cyc(1);
  endtask

  task automatic tk_pos(input int x, input int y);
    tk(1'b0, M_POS, x, y, 0, 0, 0, 0, 0);
  endtask

  // Monitor: outputs are valid one clock after a frame_tick cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (frame_tick) begin
        @(negedge clk);
        if (q.size() == 0) begin
          errs++;
          checks++;
          $display("FAIL scoreboard_underflow: got tick with no expectation, expected one queued");
        end else begin
          e = q.pop_front();
          if (e.m[0]) check("frog_x", e.tag, int'(frog_x), e.x);
          if (e.m[1]) check("frog_y", e.tag, int'(frog_y), e.y);
          if (e.m[2]) check("lives", e.tag, int'(lives), e.lv);
          if (e.m[3]) check("homes", e.tag, int'(homes), e.hm);
          if (e.m[4]) check("state", e.tag, int'(state), e.st);
          if (e.m[5]) check("frog_visible", e.tag, int'(frog_visible), e.vis);
          if (e.m[6]) check("score", e.tag, int'(score), e.sc);
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    cyc(3);
    check("rst_x", -1, int'(frog_x), 312);
    check("rst_y", -1, int'(frog_y), 448);
    check("rst_lives", -1, int'(lives), 3);
    check("rst_homes", -1, int'(homes), 0);
    check("rst_state", -1, int'(state), 0);
    check("rst_vis", -1, int'(frog_visible), 1);
    check("rst_score", -1, int'(score), 0);
    reset = 1'b1;
    cyc(2);

    // IDLE holds without start; start + tick enters PLAY
    tk(1'b0, M_ST, 0, 0, 0, 0, 0, 0, 0);
    pulse_start();
    tk(1'b0, M_FULL, 312, 448, 3, 0, 1, 0, 0);

    // Single hop, dropped second edge, priority
    press(B_UP);
    tk_pos(312, 416);
    press(B_UP);
    press(B_DN);            // dropped: up still pending
    tk_pos(312, 384);
    tk_pos(312, 384);       // nothing was queued behind it
    press(B_UP | B_RT);     // up beats right
    tk_pos(312, 352);
    press(B_DN); tk_pos(312, 384);
    press(B_DN); tk_pos(312, 416);
    press(B_DN); tk_pos(312, 448);
    press(B_DN); tk_pos(312, 448);   // clamp at spawn row

    // Right clamp, left/right priority, left floor
    for (int i = 1; i <= 20; i++) begin
      int xe;
      xe = 312 + 16 * i;
      if (xe > 624) xe = 624;
      press(B_RT);
      tk_pos(xe, 448);
    end
    press(B_LT | B_RT);     // left beats right
    tk_pos(608, 448);
    for (int i = 1; i <= 38; i++) begin
      press(B_LT);
      tk_pos(608 - 16 * i, 448);
    end
    press(B_LT);
    tk_pos(0, 448);

    // Hazard wins over a pending up; blink during DYING; respawn
    press(B_UP);
    tk(1'b1, M_ALL, 0, 448, 2, 0, 2, 1, 0);
    for (int k = 1; k <= 29; k++) begin
      if (k == 5) press(B_UP);       // ignored while dying
      if (k == 10) pulse_start();    // ignored while dying
      tk(1'b0, M_SV, 0, 0, 0, 0, 2, ((30 - k) >> 2) & 1, 0);
    end
    tk(1'b0, M_ALL, 312, 448, 2, 0, 1, 1, 0);
    tk(1'b0, M_FULL, 312, 448, 2, 0, 1, 0, 0);

    // Two more deaths -> GAME_OVER, then start -> IDLE
    tk(1'b1, M_FULL, 312, 448, 1, 0, 2, 0, 0);
    for (int k = 1; k <= 29; k++) tk(1'b0, M_NONE, 0, 0, 0, 0, 0, 0, 0);
    tk(1'b0, M_FULL, 312, 448, 1, 0, 1, 0, 0);
    tk(1'b1, M_FULL, 312, 448, 0, 0, 2, 0, 0);
    for (int k = 1; k <= 29; k++) tk(1'b0, M_NONE, 0, 0, 0, 0, 0, 0, 0);
    tk(1'b0, M_FULL, 312, 448, 0, 0, 3, 0, 0);
    tk(1'b0, M_FULL, 312, 448, 0, 0, 3, 0, 0);
    pulse_start();
    tk(1'b0, M_ST, 0, 0, 0, 0, 0, 0, 0);

    // Five homes -> WIN
    pulse_start();
    tk(1'b0, M_FULL, 312, 448, 3, 0, 1, 0, 0);
    for (int h = 1; h <= 5; h++) begin
      for (int i = 1; i <= 11; i++) begin
        press(B_UP);
        tk_pos(312, 448 - 32 * i);
      end
      press(B_UP);
      tk(1'b0, M_FULL, 312, 448, 3, h, (h == 5) ? 4 : 1, 0, 0);
    end
    tk(1'b0, 7'h58, 0, 0, 0, 5, 4, 0, WIN_SCORE);

    // Restart clears score; reset mid-DYING with a move pending
    pulse_start();
    tk(1'b0, M_ST, 0, 0, 0, 0, 0, 0, 0);
    pulse_start();
    tk(1'b0, 7'h5F, 312, 448, 3, 0, 1, 0, 0);
    press(B_UP);
    tk(1'b1, M_FULL, 312, 448, 2, 0, 2, 0, 0);
    {up, down, left, right} = B_LT;
    cyc(3);
    reset = 1'b0;
    #1;
    check("mid_rst_state", -2, int'(state), 0);
    check("mid_rst_lives", -2, int'(lives), 3);
    check("mid_rst_vis", -2, int'(frog_visible), 1);
    check("mid_rst_y", -2, int'(frog_y), 448);
    {up, down, left, right} = 4'b0000;
    cyc(2);
    reset = 1'b1;
    cyc(2);
    pulse_start();
    tk(1'b0, M_FULL, 312, 448, 3, 0, 1, 0, 0);
    tk_pos(312, 448);

    cyc(3);
    checks++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL scoreboard_drain: got %0d left over, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
